// File: rtl/mux_frame_demux.sv
// ============================================================================
// mux_frame_demux : receive end of the 4-slot digit-multiplexing link.
// Optional saturating error counter: MUX_FRAME_DEMUX_ERRCNT_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module mux_frame_demux #(
  parameter int DW      = 4,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW:0]   in_word,
  output logic [DW-1:0] d1,
  output logic [DW-1:0] d2,
  output logic [DW-1:0] d3,
  output logic [DW-1:0] d4,
  output logic          frame_valid,
  output logic          frame_err,
  output logic          sync
`ifdef MUX_FRAME_DEMUX_ERRCNT_EN
  ,
  output logic [7:0]    err_count
`endif
);

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_t        state_q, state_d;
  logic [1:0]    slot_cnt_q, slot_cnt_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [DW-1:0] sh_q [3];
  logic [DW-1:0] sh_d [3];
  logic [DW-1:0] dout_q [4];
  logic [DW-1:0] dout_d [4];
  logic          frame_valid_q, frame_valid_d;
  logic          frame_err_q, frame_err_d;

  logic          flag;
  logic [DW-1:0] data;
  logic          expire;

  assign flag = in_word[DW];
  assign data = in_word[DW-1:0];

  // Expiry fires on the idle cycle that would bring the count to TIMEOUT.
  always_comb begin
    expire = 1'b0;
    if (TIMEOUT != 0) begin
      expire = (state_q == LOCK) && (slot_cnt_q != 2'd0) && !in_valid &&
               (idle_q == IW'(TIMEOUT - 1));
    end
  end

  always_comb begin
    state_d       = state_q;
    slot_cnt_d    = slot_cnt_q;
    idle_d        = idle_q;
    sh_d          = sh_q;
    dout_d        = dout_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;

    if (in_valid) begin
      idle_d = '0;
      case (state_q)
        HUNT: begin
          if (!flag) begin
            sh_d[0]    = data;
            slot_cnt_d = 2'd1;
            state_d    = LOCK;
          end
        end
        LOCK: begin
          if (!flag) begin
            // A slot-0 word always restarts the frame; mid-frame it is an error.
            if (slot_cnt_q != 2'd0) frame_err_d = 1'b1;
            sh_d[0]    = data;
            slot_cnt_d = 2'd1;
          end else if (slot_cnt_q == 2'd0) begin
            frame_err_d = 1'b1;
            state_d     = HUNT;
          end else if (slot_cnt_q == 2'd3) begin
            dout_d[0]     = sh_q[0];
            dout_d[1]     = sh_q[1];
            dout_d[2]     = sh_q[2];
            dout_d[3]     = data;
            frame_valid_d = 1'b1;
            slot_cnt_d    = 2'd0;
          end else begin
            if (slot_cnt_q == 2'd1) sh_d[1] = data;
            else                    sh_d[2] = data;
            slot_cnt_d = slot_cnt_q + 2'd1;
          end
        end
        default: state_d = HUNT;
      endcase
    end else if (expire) begin
      frame_err_d = 1'b1;
      state_d     = HUNT;
      slot_cnt_d  = 2'd0;
      idle_d      = '0;
    end else if ((TIMEOUT != 0) && (state_q == LOCK) && (slot_cnt_q != 2'd0)) begin
      idle_d = idle_q + 1'b1;
    end else begin
      idle_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= HUNT;
      slot_cnt_q    <= 2'd0;
      idle_q        <= '0;
      sh_q          <= '{default: '0};
      dout_q        <= '{default: '0};
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_cnt_q    <= slot_cnt_d;
      idle_q        <= idle_d;
      sh_q          <= sh_d;
      dout_q        <= dout_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign d1          = dout_q[0];
  assign d2          = dout_q[1];
  assign d3          = dout_q[2];
  assign d4          = dout_q[3];
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign sync        = (state_q == LOCK);

`ifdef MUX_FRAME_DEMUX_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Counts alongside the pulse so the value moves in the cycle frame_err is high.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (frame_err_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_cnt_q <= 8'd0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_count = err_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mux_frame_demux.sv
// ============================================================================
// tb_mux_frame_demux : randomized + directed bench with a queue-based model.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mux_frame_demux;

  localparam int DW      = 4;
  localparam int TIMEOUT = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW:0]   in_word;
  logic [DW-1:0] d1, d2, d3, d4;
  logic          frame_valid, frame_err, sync;
`ifdef MUX_FRAME_DEMUX_ERRCNT_EN
  logic [7:0]    err_count;
`endif

  always #5 clk = ~clk;

  mux_frame_demux #(.DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_word     (in_word),
    .d1          (d1),
    .d2          (d2),
    .d3          (d3),
    .d4          (d4),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .sync        (sync)
`ifdef MUX_FRAME_DEMUX_ERRCNT_EN
    ,
    .err_count   (err_count)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the partial frame is just a queue of slot values.
  logic          m_locked = 1'b0;
  logic [DW-1:0] m_part[$];
  int            m_idle = 0;
  logic [4*DW-1:0] m_d = '0;
  logic          m_fv = 1'b0;
  logic          m_fe = 1'b0;
  int            m_ecnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic v, input logic [DW:0] w);
    logic          f;
    logic [DW-1:0] dat;
    f   = w[DW];
    dat = w[DW-1:0];
    m_fv = 1'b0;
    m_fe = 1'b0;
    if (r) begin
      m_locked = 1'b0;
      m_part.delete();
      m_idle = 0;
      m_d    = '0;
      m_ecnt = 0;
      return;
    end
    if (v) begin
      m_idle = 0;
      if (!f) begin
        if (m_locked && m_part.size() > 0) m_fe = 1'b1;
        m_part.delete();
        m_part.push_back(dat);
        m_locked = 1'b1;
      end else if (m_locked) begin
        if (m_part.size() == 0) begin
          m_fe     = 1'b1;
          m_locked = 1'b0;
        end else begin
          m_part.push_back(dat);
          if (m_part.size() == 4) begin
            m_d  = {m_part[0], m_part[1], m_part[2], m_part[3]};
            m_fv = 1'b1;
            m_part.delete();
          end
        end
      end
    end else if (m_locked && m_part.size() > 0 && TIMEOUT != 0) begin
      m_idle++;
      if (m_idle == TIMEOUT) begin
        m_fe     = 1'b1;
        m_locked = 1'b0;
        m_part.delete();
        m_idle   = 0;
      end
    end
    if (m_fe && m_ecnt < 255) m_ecnt++;
  endtask

  task automatic step(input logic r, input logic v, input logic [DW:0] w);
    rst      = r;
    in_valid = v;
    in_word  = w;
    @(posedge clk);
    model_step(r, v, w);
    #1;
    check("frame_valid", 32'(frame_valid), 32'(m_fv));
    check("frame_err",   32'(frame_err),   32'(m_fe));
    check("sync",        32'(sync),        32'(m_locked));
    check("d1d2d3d4",    32'({d1, d2, d3, d4}), 32'(m_d));
`ifdef MUX_FRAME_DEMUX_ERRCNT_EN
    check("err_count",   32'(err_count),   32'(m_ecnt));
`endif
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, '0);
  endtask

  initial begin
    int unsigned gpos;
    rst = 1'b1; in_valid = 1'b0; in_word = '0;

    // Basic frame
    step(1'b1, 1'b0, '0);
    check("rst_outputs", 32'({frame_valid, frame_err, sync, d1, d2, d3, d4}), 32'h0);
    step(1'b0, 1'b1, 5'h03);
    step(1'b0, 1'b1, 5'h15);
    step(1'b0, 1'b1, 5'h19);
    check("tp1_fv_early", 32'(frame_valid), 32'h0);
    step(1'b0, 1'b1, 5'h1E);
    check("tp1_fv", 32'(frame_valid), 32'h1);
    check("tp1_d", 32'({d1, d2, d3, d4}), 32'h359E);
    check("tp1_sync", 32'(sync), 32'h1);
    idle(1);
    check("tp1_fv_one_cycle", 32'(frame_valid), 32'h0);

    // HUNT ignores flag=1
    step(1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 5'h11);
    step(1'b0, 1'b1, 5'h12);
    check("tp2_no_err", 32'({frame_err, sync}), 32'h0);
    step(1'b0, 1'b1, 5'h07);
    step(1'b0, 1'b1, 5'h18);
    step(1'b0, 1'b1, 5'h19);
    step(1'b0, 1'b1, 5'h1A);
    check("tp2_d", 32'({d1, d2, d3, d4}), 32'h789A);

    // Early slot 0
    step(1'b0, 1'b1, 5'h01);
    step(1'b0, 1'b1, 5'h12);
    step(1'b0, 1'b1, 5'h04);
    check("tp3_err", 32'(frame_err), 32'h1);
    step(1'b0, 1'b1, 5'h15);
    step(1'b0, 1'b1, 5'h16);
    step(1'b0, 1'b1, 5'h17);
    check("tp3_d", 32'({d1, d2, d3, d4}), 32'h4567);

    // Missing slot 0
    step(1'b0, 1'b1, 5'h13);
    check("tp4_err_sync", 32'({frame_err, sync}), 32'h2);
    check("tp4_d_hold", 32'({d1, d2, d3, d4}), 32'h4567);

    // Timeout expiry, then a word on the expiry cycle
    step(1'b0, 1'b1, 5'h02);
    step(1'b0, 1'b1, 5'h13);
    idle(15);
    check("tp5_pre_expiry", 32'({frame_err, sync}), 32'h1);
    idle(1);
    check("tp5_expiry", 32'({frame_err, sync}), 32'h2);
    step(1'b0, 1'b1, 5'h02);
    step(1'b0, 1'b1, 5'h13);
    idle(15);
    step(1'b0, 1'b1, 5'h14);
    check("tp5_word_wins", 32'({frame_err, sync}), 32'h1);
    step(1'b0, 1'b1, 5'h15);
    check("tp5_frame", 32'({frame_valid, d1, d2, d3, d4}), 32'h12345);

    // Reset mid-frame
    step(1'b0, 1'b1, 5'h01);
    step(1'b0, 1'b1, 5'h12);
    step(1'b1, 1'b1, 5'h13);
    check("tp6_rst", 32'({frame_valid, frame_err, sync, d1, d2, d3, d4}), 32'h0);

`ifdef MUX_FRAME_DEMUX_ERRCNT_EN
    step(1'b0, 1'b1, 5'h00);
    for (int k = 0; k < 300; k++) begin
      step(1'b0, 1'b1, 5'h10);
      step(1'b0, 1'b1, 5'h00);
    end
    check("errcnt_sat", 32'(err_count), 32'd255);
    step(1'b1, 1'b0, '0);
`endif

    // Randomized stream: mostly well-formed frames with injected faults
    gpos = 0;
    for (int i = 0; i < 3000; i++) begin
      int unsigned r;
      r = $urandom_range(0, 99);
      if (r < 2) begin
        step(1'b1, 1'b0, '0);
        gpos = 0;
      end else if (r < 5) begin
        idle(int'($urandom_range(10, 20)));
      end else if (r < 25) begin
        idle(1);
      end else begin
        logic fl;
        fl = ((gpos % 4) != 0);
        if ($urandom_range(0, 9) == 0) fl = ~fl;
        step(1'b0, 1'b1, {fl, 4'($urandom_range(0, 15))});
        gpos = fl ? gpos + 1 : 1;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
